// File: rtl/n4_b2_down_counter_pkg.sv
// Shared constants for the 4-digit base-2 down counter.
package n4_b2_down_counter_pkg;

    // Number of base-2 digit cells chained in one counter stage.
    localparam int unsigned COUNTER_DIGITS = 4;

    // Count value forced while m_reset_ is low.
    localparam logic [COUNTER_DIGITS-1:0] RESET_VALUE = 4'b0000;

endpackage : n4_b2_down_counter_pkg

// File: rtl/n4_b2_down_counter_digit.sv
// One base-2 down-counting digit cell.
// The cell toggles its bit on a rising edge when borrow-in (ei) is high.
// Borrow-out (eu) is purely combinational, so a chain of cells settles within
// one cycle and every cell still updates on the same clock edge.
module b2_down_digit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic m_clock,
    input  logic m_reset_,
    input  logic ei,
    output logic q,
    output logic eu
);

    // Digit state: asynchronous clear, toggle when a borrow arrives.
    always_ff @(posedge m_clock or negedge m_reset_) begin
        if (!m_reset_) begin
            q <= RESET_BIT;
        end else if (ei) begin
            q <= ~q;
        end
    end

    // A borrow passes upward only when this digit is already 0.
    assign eu = ei & ~q;

endmodule : b2_down_digit

// File: rtl/n4_b2_down_counter.sv
// 4-digit base-2 down counter built from a ripple-borrow chain of digit cells.
// m_ei is the count enable of the least significant cell; eu is the borrow out
// of the most significant cell, so eu of one counter can drive m_ei of the next
// to form wider counters.
module n4_b2_down_counter
    import n4_b2_down_counter_pkg::*;
(
    input  logic       m_clock,
    input  logic       m_reset_,
    input  logic       m_ei,
    output logic       eu,
    output logic [3:0] q3_q0
);

    // borrow[i] is the borrow into cell i; borrow[COUNTER_DIGITS] leaves the stage.
    logic [COUNTER_DIGITS:0]   borrow;
    logic [COUNTER_DIGITS-1:0] q_bits;

    assign borrow[0] = m_ei;

    for (genvar i = 0; i < COUNTER_DIGITS; i++) begin : g_digit
        b2_down_digit #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_digit (
            .m_clock  (m_clock),
            .m_reset_ (m_reset_),
            .ei       (borrow[i]),
            .q        (q_bits[i]),
            .eu       (borrow[i+1])
        );
    end

    assign q3_q0 = q_bits;
    assign eu    = borrow[COUNTER_DIGITS];

endmodule : n4_b2_down_counter

// File: tb/tb_n4_b2_down_counter.sv
// Directed bench for n4_b2_down_counter, including a two-stage cascade.
module tb_n4_b2_down_counter;

    logic       m_clock;
    logic       m_reset_;
    logic       m_ei;
    logic       eu;
    logic [3:0] q3_q0;

    // Second stage, fed by the borrow of the first stage.
    logic       eu_b;
    logic [3:0] q_b;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    n4_b2_down_counter dut (
        .m_clock  (m_clock),
        .m_reset_ (m_reset_),
        .m_ei     (m_ei),
        .eu       (eu),
        .q3_q0    (q3_q0)
    );

    n4_b2_down_counter dut_b (
        .m_clock  (m_clock),
        .m_reset_ (m_reset_),
        .m_ei     (eu),
        .eu       (eu_b),
        .q3_q0    (q_b)
    );

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one rising edge and sample 1 ns later.
    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] e;

        // Reset with enable low.
        m_reset_ = 1'b0;
        m_ei     = 1'b0;
        #10;
        check_val("rst_q", {4'b0, q3_q0}, 8'h00);
        check_val("rst_eu", {7'b0, eu}, 8'h00);
        m_ei = 1'b1;
        #1;
        check_val("rst_eu_en", {7'b0, eu}, 8'h01);
        check_val("rst_q_en", {4'b0, q3_q0}, 8'h00);
        tick();
        check_val("rst_hold_edge", {4'b0, q3_q0}, 8'h00);

        // Count and wrap: 20 enabled edges after release.
        @(negedge m_clock);
        m_reset_ = 1'b1;
        for (int v = 15; v >= 0; v--) exp_q.push_back(8'(v));
        exp_q.push_back(8'hF);
        exp_q.push_back(8'hE);
        exp_q.push_back(8'hD);
        exp_q.push_back(8'hC);
        for (int k = 0; k < 20; k++) begin
            tick();
            e = exp_q.pop_front();
            check_val($sformatf("cnt_q%0d", k), {4'b0, q3_q0}, e);
            check_val($sformatf("cnt_eu%0d", k), {7'b0, eu}, (e == 8'h00) ? 8'h01 : 8'h00);
        end

        // Move to 1010 then hold for 3 edges.
        tick_n(2);
        check_val("pre_hold", {4'b0, q3_q0}, 8'b0000_1010);
        m_ei = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("hold_q", {4'b0, q3_q0}, 8'b0000_1010);
            check_val("hold_eu", {7'b0, eu}, 8'h00);
        end
        m_ei = 1'b1;
        tick();
        check_val("hold_resume", {4'b0, q3_q0}, 8'b0000_1001);

        // Borrow gating at 0000.
        tick_n(9);
        check_val("gate_zero", {4'b0, q3_q0}, 8'h00);
        check_val("gate_eu1", {7'b0, eu}, 8'h01);
        m_ei = 1'b0;
        #1;
        check_val("gate_eu_lo", {7'b0, eu}, 8'h00);
        m_ei = 1'b1;
        #1;
        check_val("gate_eu_hi", {7'b0, eu}, 8'h01);
        m_ei = 1'b0;
        #1;
        check_val("gate_eu_lo2", {7'b0, eu}, 8'h00);
        tick();
        check_val("gate_noedge", {4'b0, q3_q0}, 8'h00);
        m_ei = 1'b1;
        #1;
        check_val("gate_eu_hi2", {7'b0, eu}, 8'h01);
        tick();
        check_val("gate_wrap", {4'b0, q3_q0}, 8'h0F);
        check_val("gate_wrap_eu", {7'b0, eu}, 8'h00);

        // Async reset mid-count at 0110.
        tick_n(9);
        check_val("ar_pre", {4'b0, q3_q0}, 8'b0000_0110);
        #2;
        m_reset_ = 1'b0;
        #1;
        check_val("ar_q", {4'b0, q3_q0}, 8'h00);
        check_val("ar_eu", {7'b0, eu}, 8'h01);
        @(negedge m_clock);
        m_reset_ = 1'b1;
        tick();
        check_val("ar_resume", {4'b0, q3_q0}, 8'h0F);

        // Cascade: both stages from reset, 40 enabled edges.
        @(negedge m_clock);
        m_reset_ = 1'b0;
        #1;
        check_val("cas_rst", {q_b, q3_q0}, 8'h00);
        m_reset_ = 1'b1;
        m_ei     = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            e = 8'(256 - k);
            check_val($sformatf("cas_k%0d", k), {q_b, q3_q0}, e);
        end
        check_val("cas_eu_b", {7'b0, eu_b}, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_n4_b2_down_counter
